// File: rtl/out_uart_tx.sv
// 8N1 UART transmitter fed from the CPU output register. A one-shot arm flag
// makes a held-high fgo produce exactly one frame.
module out_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fgo,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       ack,
  output logic       done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_param
      $error("out_uart_tx: CLKS_PER_BIT must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic            armed_q, armed_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            ack_q, ack_d;
  logic            done_q, done_d;
  logic            baud_end;

  assign baud_end = (baud_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      armed_q <= 1'b1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      armed_q <= armed_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    // fgo low at any edge (even mid-frame) re-arms for the next byte
    armed_d = armed_q | ~fgo;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (fgo && armed_q) begin
          shreg_d = data_in;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          ack_d   = 1'b1;
          armed_d = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          tx_d    = shreg_q[0];
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign ack  = ack_q;
  assign done = done_q;

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: table of frames plus hand sequences; an independent
// line decoder pops expected bytes from a scoreboard queue.
module tb_out_uart_tx;

  logic       clk = 1'b0;
  logic       rst4_n = 1'b1, rst2_n = 1'b1;
  logic       fgo4 = 1'b0, fgo2 = 1'b0;
  logic [7:0] data4 = '0, data2 = '0;
  logic       tx4, busy4, ack4, done4;
  logic       tx2, busy2, ack2, done2;

  int tests = 0, fails = 0;
  int acks = 0, dones = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  out_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .fgo(fgo4), .data_in(data4),
    .tx(tx4), .busy(busy4), .ack(ack4), .done(done4));

  out_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .fgo(fgo2), .data_in(data2),
    .tx(tx2), .busy(busy2), .ack(ack2), .done(done2));

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // line bits in send order, frame[0] = start bit
    string      name;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ack4(input string nm);
    int t = 0;
    do begin @(posedge clk); #1; t++; end while (!ack4 && t < 60);
    chk(nm, 32'(ack4), 32'd1);
  endtask

  task automatic wait_done4(input string nm);
    int t = 0;
    do begin @(posedge clk); #1; t++; end while (!done4 && t < 60);
    chk(nm, 32'(done4), 32'd1);
  endtask

  // Sends one byte on dut4 and checks every line cycle of the 40-cycle frame.
  task automatic frame4(input logic [7:0] d, input logic [9:0] exp, input string nm);
    logic [9:0] got;
    int bad, nack;
    data4 = d; fgo4 = 1'b1; sb.push_back(d);
    wait_ack4({nm, " ack"});
    chk({nm, " busy"}, 32'(busy4), 32'd1);
    got = '0; bad = 0; nack = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin @(posedge clk); #1; nack += int'(ack4); end
      if (c % 4 == 2) got[c/4] = tx4;
      if (tx4 !== exp[c/4]) bad++;
      if (done4 || !busy4) bad++;
    end
    chk({nm, " bits"}, 32'(got), 32'(exp));
    chk({nm, " bit-hold"}, 32'(bad), 32'd0);
    chk({nm, " ack-width"}, 32'(nack), 32'd0);
    @(posedge clk); #1;
    chk({nm, " done/busy/tx"}, {29'd0, done4, busy4, tx4}, 32'b101);
    fgo4 = 1'b0;
  endtask

  // Independent line decoder for dut4, sampling mid-bit.
  initial begin : monitor
    bit in_f = 0;
    int cnt = 0;
    logic [7:0] rx = '0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst4_n) in_f = 0;
      else if (!in_f) begin
        if (tx4 === 1'b0) begin in_f = 1; cnt = 0; end
      end else begin
        cnt++;
        if (cnt % 4 == 2 && cnt / 4 >= 1 && cnt / 4 <= 8) rx[cnt/4 - 1] = tx4;
        if (cnt == 38) begin
          in_f = 0;
          chk("sb stop bit", 32'(tx4), 32'd1);
          if (sb.size() == 0) chk("sb unexpected frame", 32'(rx), 32'hFFFF_FFFF);
          else begin e = sb.pop_front(); chk("sb byte", 32'(rx), 32'(e)); end
        end
      end
      if (ack4) acks++;
      if (done4) dones++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t vecs[4];
    int a0, d0, bad, lows, highs, t;
    vecs[0] = '{8'hA5, 10'b1101001010, "A5"};
    vecs[1] = '{8'h00, 10'b1000000000, "00"};
    vecs[2] = '{8'hFF, 10'b1111111110, "FF"};
    vecs[3] = '{8'h5A, 10'b1010110100, "5A"};

    // 1: asynchronous reset, no edge needed
    #2; rst4_n = 1'b0; rst2_n = 1'b0; #1;
    chk("reset outputs", {28'd0, tx4, busy4, ack4, done4}, 32'b1000);
    chk("reset outputs dut2", {28'd0, tx2, busy2, ack2, done2}, 32'b1000);
    @(negedge clk); rst4_n = 1'b1; rst2_n = 1'b1;
    bad = 0;
    repeat (10) begin @(posedge clk); #1; if (tx4 !== 1'b1 || busy4) bad++; end
    chk("idle after reset", 32'(bad), 32'd0);

    // 2: table of single frames, one fgo-low edge between entries to re-arm
    for (int i = 0; i < 4; i++) begin
      frame4(vecs[i].data, vecs[i].frame, vecs[i].name);
      @(posedge clk); #1;
    end
    chk("table ack count", 32'(acks), 32'd4);
    chk("table done count", 32'(dones), 32'd4);

    // 3: held flag gives one frame
    a0 = acks; d0 = dones;
    data4 = 8'hA5; fgo4 = 1'b1; sb.push_back(8'hA5);
    repeat (200) @(posedge clk); #1;
    chk("held acks", 32'(acks - a0), 32'd1);
    chk("held dones", 32'(dones - d0), 32'd1);
    fgo4 = 1'b0; @(posedge clk); #1;

    // 4: re-arm during a frame; byte 1 is frozen, byte 2 follows one idle cycle
    data4 = 8'h3C; fgo4 = 1'b1; sb.push_back(8'h3C);
    wait_ack4("rearm ack1");
    repeat (5) @(posedge clk); #1;
    fgo4 = 1'b0; data4 = 8'hC3;
    @(posedge clk); #1;
    fgo4 = 1'b1; sb.push_back(8'hC3);
    wait_done4("rearm done1");
    chk("rearm idle gap", {29'd0, tx4, ack4, busy4}, 32'b100);
    @(posedge clk); #1;
    chk("rearm accept2", {29'd0, tx4, ack4, busy4}, 32'b011);
    wait_done4("rearm done2");
    fgo4 = 1'b0; @(posedge clk); #1;
    chk("rearm sb drained", 32'(sb.size()), 32'd0);

    // 5: reset in the middle of an FF frame
    data4 = 8'hFF; fgo4 = 1'b1; sb.push_back(8'hFF);
    wait_ack4("midrst ack");
    repeat (17) @(posedge clk);
    #2; rst4_n = 1'b0; #1;
    chk("midrst outputs", {28'd0, tx4, busy4, ack4, done4}, 32'b1000);
    sb.delete(); fgo4 = 1'b0; d0 = dones;
    #10; rst4_n = 1'b1;
    bad = 0;
    repeat (45) begin @(posedge clk); #1; if (tx4 !== 1'b1 || busy4) bad++; end
    chk("midrst no done", 32'(dones - d0), 32'd0);
    chk("midrst idle line", 32'(bad), 32'd0);
    frame4(8'hFF, 10'b1111111110, "post-rst FF");
    @(posedge clk); #1;

    // 6: CLKS_PER_BIT=2 with a zero byte
    data2 = 8'h00; fgo2 = 1'b1; t = 0;
    do begin @(posedge clk); #1; t++; end while (!ack2 && t < 20);
    chk("cpb2 ack", 32'(ack2), 32'd1);
    lows = 0; highs = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c < 18 && tx2 === 1'b0) lows++;
      if (c >= 18 && tx2 === 1'b1) highs++;
    end
    chk("cpb2 low cycles", 32'(lows), 32'd18);
    chk("cpb2 high cycles", 32'(highs), 32'd2);
    @(posedge clk); #1;
    chk("cpb2 done/busy", {30'd0, done2, busy2}, 32'b10);
    fgo2 = 1'b0;
    @(posedge clk); #1;
    chk("cpb2 done width", 32'(done2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
